// File: rtl/indexed_accum_bank.sv
// rtl/indexed_accum_bank.sv - bank of DEPTH WIDTH-bit accumulators behind valid/ready request/result handshakes
// Read-modify-write happens at the accept edge; the result sits in a single-entry output register.
module indexed_accum_bank #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cb,
  output logic             out_err
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic             out_valid_q;
  logic [IDXW-1:0]  out_idx_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_cb_q, out_cb_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             idx_ok;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             write_en;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_ok   = {1'b0, in_idx} < (IDXW+1)'(DEPTH);

  // Explicit select loop so an out-of-range index never reads past the array.
  always_comb begin
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_idx == IDXW'(i)) acc = bank_q[i];
    end
  end

  assign sum  = {1'b0, acc} + {1'b0, in_data};
  assign diff = {1'b0, acc} - {1'b0, in_data};

  always_comb begin
    out_data_d = '0;
    out_cb_d   = 1'b0;
    out_err_d  = 1'b0;
    if (!idx_ok) begin
      out_err_d = 1'b1;
    end else begin
      unique case (in_op)
        OP_ADD: begin
          out_data_d = sum[WIDTH-1:0];
          out_cb_d   = sum[WIDTH];
        end
        OP_SUB: begin
          out_data_d = diff[WIDTH-1:0];
          out_cb_d   = diff[WIDTH];
        end
        OP_LOAD: out_data_d = in_data;
        OP_READ: out_data_d = acc;
        default: out_data_d = '0;
      endcase
    end
  end

  assign write_en = accept && idx_ok && (in_op != OP_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (write_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (in_idx == IDXW'(i)) bank_q[i] <= out_data_d;
      end
    end
  end

  // A new accept overwrites the register even if the old result is being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_cb_q    <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_idx_q   <= in_idx;
      out_data_q  <= out_data_d;
      out_cb_q    <= out_cb_d;
      out_err_q   <= out_err_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_cb    = out_cb_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_indexed_accum_bank.sv
// tb/tb_indexed_accum_bank.sv - scoreboard bench for indexed_accum_bank (DEPTH=8 and DEPTH=6 instances)
// Expected results come from an arithmetic model of the bank; a monitor pops them as results are consumed.
module tb_indexed_accum_bank;

  typedef struct {
    int idx;
    int data;
    int cb;
    int err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       vld   [2];
  logic       rdy   [2];
  logic [2:0] idx   [2];
  logic [1:0] op    [2];
  logic [3:0] dat   [2];
  logic       ov    [2];
  logic       ordy  [2];
  logic [2:0] oidx  [2];
  logic [3:0] odata [2];
  logic       ocb   [2];
  logic       oerr  [2];

  int   errors;
  int   checks;
  int   bank [2][8];
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  bit   held [2];
  exp_t held_v [2];
  bit   rnd_ready;
  int   last_wait;

  indexed_accum_bank #(.WIDTH(4), .DEPTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[0]), .in_ready(rdy[0]), .in_idx(idx[0]), .in_op(op[0]), .in_data(dat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(oidx[0]), .out_data(odata[0]),
    .out_cb(ocb[0]), .out_err(oerr[0])
  );

  indexed_accum_bank #(.WIDTH(4), .DEPTH(6)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[1]), .in_ready(rdy[1]), .in_idx(idx[1]), .in_op(op[1]), .in_data(dat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(oidx[1]), .out_data(odata[1]),
    .out_cb(ocb[1]), .out_err(oerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic void model(input int d, input int ix, input int o, input int x);
    exp_t e;
    int   s;
    e.idx = ix; e.data = 0; e.cb = 0; e.err = 0;
    if (ix >= depth_of(d)) begin
      e.err = 1;
    end else begin
      case (o)
        0: begin
          s = bank[d][ix] + x;
          e.data = s % 16;
          e.cb = (s >= 16) ? 1 : 0;
          bank[d][ix] = e.data;
        end
        1: begin
          e.cb = (x > bank[d][ix]) ? 1 : 0;
          e.data = (bank[d][ix] - x + 16) % 16;
          bank[d][ix] = e.data;
        end
        2: begin
          e.data = x;
          bank[d][ix] = x;
        end
        default: e.data = bank[d][ix];
      endcase
    end
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  task automatic issue(input int d, input int ix, input int o, input int x);
    int  k;
    bit  ok;
    vld[d] = 1'b1;
    idx[d] = 3'(ix);
    op[d]  = 2'(o);
    dat[d] = 4'(x);
    k = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy[d]) begin
        ok = 1'b1;
        break;
      end
      k++;
      if (k > 100) begin
        chk("accept_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      if (rnd_ready) ordy[d] = ($urandom_range(0, 3) != 0);
    end
    last_wait = k;
    if (ok) model(d, ix, o, x);
    @(posedge clk); #1;
    vld[d] = 1'b0;
    dat[d] = 4'($urandom_range(0, 15));
    if (rnd_ready) ordy[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int k;
    rnd_ready = 1'b0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (!ov[d]) begin
      held[d] = 1'b0;
      return;
    end
    if (held[d]) begin
      chk("stable_idx", int'(oidx[d]), held_v[d].idx);
      chk("stable_data", int'(odata[d]), held_v[d].data);
      chk("stable_cb", int'(ocb[d]), held_v[d].cb);
      chk("stable_err", int'(oerr[d]), held_v[d].err);
    end
    if (ordy[d]) begin
      held[d] = 1'b0;
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("out_idx", int'(oidx[d]), e.idx);
        chk("out_data", int'(odata[d]), e.data);
        chk("out_cb", int'(ocb[d]), e.cb);
        chk("out_err", int'(oerr[d]), e.err);
      end
    end else if (!held[d]) begin
      held[d] = 1'b1;
      held_v[d].idx  = int'(oidx[d]);
      held_v[d].data = int'(odata[d]);
      held_v[d].cb   = int'(ocb[d]);
      held_v[d].err  = int'(oerr[d]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rnd_ready = 1'b0;
    last_wait = 0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; idx[d] = '0; op[d] = '0; dat[d] = '0; ordy[d] = 1'b1; held[d] = 1'b0;
      for (int i = 0; i < 8; i++) bank[d][i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid0", int'(ov[0]), 0);
    chk("reset_out_valid1", int'(ov[1]), 0);
    chk("reset_in_ready0", int'(rdy[0]), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(0, i, 3, 0);
    issue(0, 3, 2, 12);
    issue(0, 3, 0, 5);
    issue(0, 3, 3, 0);
    issue(0, 0, 2, 0);
    issue(0, 0, 1, 1);
    issue(0, 0, 1, 12);
    for (int i = 1; i < 8; i++) issue(0, i, 3, 0);

    issue(0, 1, 2, 5);
    ordy[0] = 1'b0;
    vld[0] = 1'b1; idx[0] = 3'd1; op[0] = 2'd0; dat[0] = 4'd2;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", int'(rdy[0]), 0);
      chk("stall_out_valid", int'(ov[0]), 1);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    issue(0, 1, 0, 2);
    issue(0, 1, 0, 3);
    chk("throughput_a", last_wait, 0);
    issue(0, 1, 3, 0);
    chk("throughput_b", last_wait, 0);

    issue(1, 7, 0, 3);
    issue(1, 5, 2, 9);
    issue(1, 6, 0, 4);
    for (int i = 0; i < 6; i++) issue(1, i, 3, 0);
    drain();

    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      issue(n % 2, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    drain();

    ordy[0] = 1'b0;
    issue(0, 2, 2, 7);
    @(negedge clk);
    chk("pre_reset_out_valid", int'(ov[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid0", int'(ov[0]), 0);
    chk("async_reset_out_valid1", int'(ov[1]), 0);
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) bank[d][i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) issue(0, i, 3, 0);
    for (int i = 0; i < 6; i++) issue(1, i, 3, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
